// File: rtl/cvxif_mac4b_offload_ctrl.sv
// Core-side CV-X-IF initiator for MAC4B offloads: issue, id tracking, in-order commit/kill, result writeback.
// Optional local pre-decode of the instruction word is enabled by defining CVXIF_MAC4B_LOCAL_DECODE_EN.
module cvxif_mac4b_offload_ctrl #(
   parameter int unsigned IdWidth = 3,
   parameter int unsigned Depth   = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               instr_valid_i,
   output logic               instr_ready_o,
   input  logic [31:0]        instr_i,
   input  logic [2:0][31:0]   rs_i,
   output logic               x_issue_valid_o,
   input  logic               x_issue_ready_i,
   output logic [31:0]        x_issue_instr_o,
   output logic [IdWidth-1:0] x_issue_id_o,
   output logic [2:0][31:0]   x_issue_rs_o,
   output logic [2:0]         x_issue_rs_valid_o,
   input  logic               x_issue_accept_i,
   input  logic               x_issue_wb_i,
   input  logic               commit_valid_i,
   input  logic               commit_kill_i,
   output logic               x_commit_valid_o,
   output logic [IdWidth-1:0] x_commit_id_o,
   output logic               x_commit_kill_o,
   input  logic               x_result_valid_i,
   output logic               x_result_ready_o,
   input  logic [IdWidth-1:0] x_result_id_i,
   input  logic [31:0]        x_result_data_i,
   input  logic [4:0]         x_result_rd_i,
   input  logic               x_result_we_i,
   output logic               wb_valid_o,
   output logic [IdWidth-1:0] wb_id_o,
   output logic [31:0]        wb_data_o,
   output logic [4:0]         wb_rd_o,
   output logic               wb_we_o,
   output logic               wb_exc_o,
   output logic               spurious_o
);

   localparam int unsigned NumIds = 1 << IdWidth;
   localparam int unsigned CntW   = IdWidth + 1;

   // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both high;
   // the initiator holds valid and its payload stable until that edge.
   typedef enum logic [1:0] {IDLE, ISSUE, REJECT} state_t;
   state_t state, state_nxt;

   logic [31:0]        instr_q;
   logic [2:0][31:0]   rs_q;
   logic [IdWidth-1:0] id_cnt;
   logic [NumIds-1:0]  out_tbl, out_nxt, wb_tbl;
   logic [CntW-1:0]    out_cnt, cq_cnt;
   logic [IdWidth-1:0] cq_mem [NumIds];
   logic [IdWidth-1:0] cq_wr, cq_rd, cq_head;
   logic               wb_valid_q, wb_we_q, spurious_q;
   logic [IdWidth-1:0] wb_id_q;
   logic [31:0]        wb_data_q;
   logic [4:0]         wb_rd_q;
   logic               commit_valid_q, commit_kill_q;
   logic [IdWidth-1:0] commit_id_q;
   logic               decode_ok, rej;
   logic               instr_hs, issue_hs, accept_hs, res_hs, res_hit, commit_pop;

`ifdef CVXIF_MAC4B_LOCAL_DECODE_EN
   assign decode_ok = (instr_q & 32'h0600_707F) == 32'h0600_0033;
`else
   assign decode_ok = 1'b1;
`endif

   assign rej        = (state == REJECT);
   assign instr_hs   = instr_valid_i & instr_ready_o;
   assign issue_hs   = x_issue_valid_o & x_issue_ready_i;
   assign accept_hs  = issue_hs & x_issue_accept_i;
   assign res_hs     = x_result_valid_i & x_result_ready_o;
   assign res_hit    = res_hs & out_tbl[x_result_id_i];
   assign commit_pop = commit_valid_i & (cq_cnt != '0);
   assign cq_head    = cq_mem[cq_rd];

   always_comb begin
      out_cnt = '0;
      for (int i = 0; i < NumIds; i++) out_cnt = out_cnt + CntW'(out_tbl[i]);
   end

   // The queue-full and id-busy terms keep a wrapped id from aliasing one still in flight.
   assign instr_ready_o = (state == IDLE) && (out_cnt < CntW'(Depth)) &&
                          (cq_cnt < CntW'(NumIds)) && !out_tbl[id_cnt];

   always_comb begin
      state_nxt       = state;
      x_issue_valid_o = 1'b0;
      case (state)
         IDLE:   if (instr_hs) state_nxt = ISSUE;
         ISSUE: begin
            if (!decode_ok) begin
               state_nxt = REJECT;
            end else begin
               x_issue_valid_o = 1'b1;
               if (x_issue_ready_i) state_nxt = x_issue_accept_i ? IDLE : REJECT;
            end
         end
         REJECT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_nxt = out_tbl;
      if (commit_pop && (commit_kill_i || !wb_tbl[cq_head])) out_nxt[cq_head] = 1'b0;
      if (res_hit) out_nxt[x_result_id_i] = 1'b0;
      if (accept_hs) out_nxt[id_cnt] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         instr_q <= '0;
         rs_q    <= '0;
         id_cnt  <= '0;
         out_tbl <= '0;
         wb_tbl  <= '0;
      end else begin
         state   <= state_nxt;
         out_tbl <= out_nxt;
         if (instr_hs) begin
            instr_q <= instr_i;
            rs_q    <= rs_i;
         end
         if (accept_hs) begin
            wb_tbl[id_cnt] <= x_issue_wb_i;
            id_cnt         <= id_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept_hs) cq_mem[cq_wr] <= id_cnt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cq_wr          <= '0;
         cq_rd          <= '0;
         cq_cnt         <= '0;
         commit_valid_q <= 1'b0;
         commit_id_q    <= '0;
         commit_kill_q  <= 1'b0;
      end else begin
         if (accept_hs) cq_wr <= cq_wr + 1'b1;
         if (commit_pop) cq_rd <= cq_rd + 1'b1;
         case ({accept_hs, commit_pop})
            2'b10:   cq_cnt <= cq_cnt + 1'b1;
            2'b01:   cq_cnt <= cq_cnt - 1'b1;
            default: cq_cnt <= cq_cnt;
         endcase
         commit_valid_q <= commit_pop;
         commit_kill_q  <= commit_pop & commit_kill_i;
         if (commit_pop) commit_id_q <= cq_head;
      end
   end

   // A result taken the cycle before REJECT stays pending and is shown right after the exception.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_q <= 1'b0;
         wb_id_q    <= '0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_we_q    <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         spurious_q <= res_hs & ~res_hit;
         if (res_hit) begin
            wb_valid_q <= 1'b1;
            wb_id_q    <= x_result_id_i;
            wb_data_q  <= x_result_data_i;
            wb_rd_q    <= x_result_rd_i;
            wb_we_q    <= x_result_we_i;
         end else if (!rej) begin
            wb_valid_q <= 1'b0;
         end
      end
   end

   assign x_issue_instr_o    = instr_q;
   assign x_issue_id_o       = id_cnt;
   assign x_issue_rs_o       = rs_q;
   assign x_issue_rs_valid_o = 3'b111;
   assign x_result_ready_o   = !rej;
   assign x_commit_valid_o   = commit_valid_q;
   assign x_commit_id_o      = commit_id_q;
   assign x_commit_kill_o    = commit_kill_q;
   assign wb_valid_o         = rej | wb_valid_q;
   assign wb_id_o            = rej ? id_cnt : wb_id_q;
   assign wb_data_o          = rej ? 32'h0 : wb_data_q;
   assign wb_rd_o            = rej ? 5'd0 : wb_rd_q;
   assign wb_we_o            = rej ? 1'b0 : wb_we_q;
   assign wb_exc_o           = rej;
   assign spurious_o         = spurious_q;

endmodule

// File: tb/tb_cvxif_mac4b_offload_ctrl.sv
// Directed bench for cvxif_mac4b_offload_ctrl: issue, reject, full, kill/spurious, id wrap, reset.
module tb_cvxif_mac4b_offload_ctrl;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             instr_valid, instr_ready;
   logic [31:0]      instr;
   logic [2:0][31:0] rs;
   logic             x_issue_valid, x_issue_ready;
   logic [31:0]      x_issue_instr;
   logic [2:0]       x_issue_id;
   logic [2:0][31:0] x_issue_rs;
   logic [2:0]       x_issue_rs_valid;
   logic             x_issue_accept, x_issue_wb;
   logic             commit_valid, commit_kill;
   logic             x_commit_valid, x_commit_kill;
   logic [2:0]       x_commit_id;
   logic             x_result_valid, x_result_ready;
   logic [2:0]       x_result_id;
   logic [31:0]      x_result_data;
   logic [4:0]       x_result_rd;
   logic             x_result_we;
   logic             wb_valid, wb_we, wb_exc, spurious;
   logic [2:0]       wb_id;
   logic [31:0]      wb_data;
   logic [4:0]       wb_rd;

   int n_checks = 0;
   int n_pass   = 0;

   cvxif_mac4b_offload_ctrl #(.IdWidth(3), .Depth(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr), .rs_i(rs),
      .x_issue_valid_o(x_issue_valid), .x_issue_ready_i(x_issue_ready),
      .x_issue_instr_o(x_issue_instr), .x_issue_id_o(x_issue_id), .x_issue_rs_o(x_issue_rs),
      .x_issue_rs_valid_o(x_issue_rs_valid), .x_issue_accept_i(x_issue_accept), .x_issue_wb_i(x_issue_wb),
      .commit_valid_i(commit_valid), .commit_kill_i(commit_kill),
      .x_commit_valid_o(x_commit_valid), .x_commit_id_o(x_commit_id), .x_commit_kill_o(x_commit_kill),
      .x_result_valid_i(x_result_valid), .x_result_ready_o(x_result_ready), .x_result_id_i(x_result_id),
      .x_result_data_i(x_result_data), .x_result_rd_i(x_result_rd), .x_result_we_i(x_result_we),
      .wb_valid_o(wb_valid), .wb_id_o(wb_id), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
      .wb_we_o(wb_we), .wb_exc_o(wb_exc), .spurious_o(spurious)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_valid = 0; instr = '0; rs = '0;
      x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0;
      commit_valid = 0; commit_kill = 0;
      x_result_valid = 0; x_result_id = '0; x_result_data = '0; x_result_rd = '0; x_result_we = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      #1;
      check("rst_issue_valid", x_issue_valid, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_commit_valid", x_commit_valid, 0);
      check("rst_spurious", spurious, 0);
      step();
      rst_n = 1;
      step();
      check("rst_instr_ready", instr_ready, 1);
   endtask

   // Offers one instruction and answers the issue request; leaves the DUT just after the issue handshake.
   task automatic offload(input logic [31:0] iw, input logic acc, input logic wbf, input logic [2:0] exp_id);
      check("pre_instr_ready", instr_ready, 1);
      instr_valid = 1; instr = iw;
      rs[0] = iw ^ 32'h1111_1111; rs[1] = iw ^ 32'h2222_2222; rs[2] = iw ^ 32'h3333_3333;
      step();
      instr_valid = 0;
      check("issue_valid", x_issue_valid, 1);
      check("issue_instr", x_issue_instr, iw);
      check("issue_id", x_issue_id, exp_id);
      check("issue_rs2", x_issue_rs[2], iw ^ 32'h3333_3333);
      x_issue_ready = 1; x_issue_accept = acc; x_issue_wb = wbf;
      step();
      x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0;
   endtask

   task automatic result(input logic [2:0] id, input logic [31:0] data, input logic [4:0] rd);
      check("result_ready", x_result_ready, 1);
      x_result_valid = 1; x_result_id = id; x_result_data = data; x_result_rd = rd; x_result_we = 1;
      step();
      x_result_valid = 0;
   endtask

   task automatic expect_wb(input logic [2:0] id, input logic [31:0] data, input logic [4:0] rd);
      check("wb_valid", wb_valid, 1);
      check("wb_id", wb_id, id);
      check("wb_data", wb_data, data);
      check("wb_rd", wb_rd, rd);
      check("wb_exc", wb_exc, 0);
   endtask

   task automatic commit(input logic kill, input logic [2:0] exp_id);
      commit_valid = 1; commit_kill = kill;
      step();
      commit_valid = 0; commit_kill = 0;
      check("commit_valid", x_commit_valid, 1);
      check("commit_id", x_commit_id, exp_id);
      check("commit_kill", x_commit_kill, kill);
   endtask

   initial begin
      do_reset();
      check("rs_valid_const", x_issue_rs_valid, 3'b111);

      // Accepted offload with writeback, held one extra cycle before the coprocessor takes it.
      instr_valid = 1; instr = 32'h0600_00B3; rs[0] = 32'd1; rs[1] = 32'd2; rs[2] = 32'd3;
      step();
      instr_valid = 0;
      step();
      check("hold_valid", x_issue_valid, 1);
      check("hold_instr", x_issue_instr, 32'h0600_00B3);
      check("hold_rs0", x_issue_rs[0], 32'd1);
      check("hold_id", x_issue_id, 0);
      x_issue_ready = 1; x_issue_accept = 1; x_issue_wb = 1;
      step();
      x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0;
      check("no_early_wb", wb_valid, 0);
      result(3'd0, 32'h1234, 5'd1);
      expect_wb(3'd0, 32'h1234, 5'd1);
      check("wb_we", wb_we, 1);
      step();
      check("wb_one_cycle", wb_valid, 0);
      commit(1'b0, 3'd0);
      step();
      check("commit_one_cycle", x_commit_valid, 0);

      // Rejected offload: exception for one cycle, id not consumed, nothing queued.
      offload(32'h0600_00B3, 1'b0, 1'b0, 3'd1);
      check("rej_wb_valid", wb_valid, 1);
      check("rej_exc", wb_exc, 1);
      check("rej_we", wb_we, 0);
      check("rej_id", wb_id, 1);
      check("rej_res_ready", x_result_ready, 0);
      step();
      check("rej_done", wb_valid, 0);
      commit_valid = 1;
      step();
      commit_valid = 0;
      check("empty_commit", x_commit_valid, 0);

      // Fill to Depth, then free one via a result.
      for (int k = 1; k <= 4; k++) offload(32'h0600_00B3 + 32'(k << 7), 1'b1, 1'b1, 3'(k));
      check("full_blocks", instr_ready, 0);
      result(3'd2, 32'hBEEF, 5'd9);
      expect_wb(3'd2, 32'hBEEF, 5'd9);
      check("unblocked", instr_ready, 1);

      // Kill the oldest (id1), then its late result is dropped.
      commit(1'b1, 3'd1);
      result(3'd1, 32'hDEAD, 5'd3);
      check("spurious_pulse", spurious, 1);
      check("spurious_no_wb", wb_valid, 0);
      step();
      check("spurious_one_cycle", spurious, 0);

      // Reset with ids 2..4 still queued: nothing is committed afterwards.
      do_reset();
      commit_valid = 1;
      step();
      commit_valid = 0;
      check("reset_no_commit", x_commit_valid, 0);

      // Nine issue/result/commit rounds wrap the 3-bit id.
      for (int k = 0; k < 9; k++) begin
         offload(32'h0600_00B3, 1'b1, 1'b1, 3'(k % 8));
         result(3'(k % 8), 32'hA000 + 32'(k), 5'(k + 1));
         expect_wb(3'(k % 8), 32'hA000 + 32'(k), 5'(k + 1));
         commit(1'b0, 3'(k % 8));
      end

`ifdef CVXIF_MAC4B_LOCAL_DECODE_EN
      step();
      instr_valid = 1; instr = 32'h0000_0033;
      step();
      instr_valid = 0;
      check("dec_no_issue", x_issue_valid, 0);
      check("dec_no_exc_yet", wb_exc, 0);
      step();
      check("dec_exc", wb_exc, 1);
      check("dec_wb_valid", wb_valid, 1);
      check("dec_id", wb_id, 1);
      step();
      check("dec_exc_done", wb_exc, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
